// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS control sequencer: steps a shared datapath through FETCH/DECODE/EXEC/MEM/WB
// against a variable-latency req/ack memory, with retire pulse, sticky timeout and illegal flags.
module mccpu_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] NPCOp,
  output logic       RegWrite,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       ALUSrcB,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [2:0] state,
  output logic       retire,
  output logic       timeout,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_JALR
  } class_e;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SLLV = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             illegal_q, illegal_d;

  class_e     dec_class;
  logic [3:0] dec_alu;
  logic       dec_ext;

  // Instruction decode, independent of state; only consumed from DECODE onward.
  always_comb begin
    dec_class = C_ILL;
    dec_alu   = ALU_NOP;
    dec_ext   = 1'b0;
    case (Op)
      6'h00: begin
        case (Funct)
          6'h20, 6'h21: begin dec_class = C_RALU; dec_alu = ALU_ADD;  end
          6'h22, 6'h23: begin dec_class = C_RALU; dec_alu = ALU_SUB;  end
          6'h24:        begin dec_class = C_RALU; dec_alu = ALU_AND;  end
          6'h25:        begin dec_class = C_RALU; dec_alu = ALU_OR;   end
          6'h27:        begin dec_class = C_RALU; dec_alu = ALU_NOR;  end
          6'h2a:        begin dec_class = C_RALU; dec_alu = ALU_SLT;  end
          6'h2b:        begin dec_class = C_RALU; dec_alu = ALU_SLTU; end
          6'h00:        begin dec_class = C_RALU; dec_alu = ALU_SLL;  end
          6'h02:        begin dec_class = C_RALU; dec_alu = ALU_SRL;  end
          6'h04:        begin dec_class = C_RALU; dec_alu = ALU_SLLV; end
          6'h06:        begin dec_class = C_RALU; dec_alu = ALU_SRLV; end
          6'h08:        dec_class = C_JR;
          6'h09:        dec_class = C_JALR;
          default:      dec_class = C_ILL;
        endcase
      end
      6'h08:   begin dec_class = C_IALU; dec_alu = ALU_ADD; dec_ext = 1'b1; end
      6'h0a:   begin dec_class = C_IALU; dec_alu = ALU_SLT; dec_ext = 1'b1; end
      6'h0c:   begin dec_class = C_IALU; dec_alu = ALU_AND; end
      6'h0d:   begin dec_class = C_IALU; dec_alu = ALU_OR;  end
      6'h0f:   begin dec_class = C_IALU; dec_alu = ALU_LUI; end
      6'h23:   dec_class = C_LW;
      6'h2b:   dec_class = C_SW;
      6'h04:   dec_class = C_BEQ;
      6'h05:   dec_class = C_BNE;
      6'h02:   dec_class = C_J;
      6'h03:   dec_class = C_JAL;
      default: dec_class = C_ILL;
    endcase
  end

  logic req_s, we_s, irw_s, pcw_s, rw_s, ret_s;

  always_comb begin
    state_d  = state_q;
    req_s    = 1'b0;
    we_s     = 1'b0;
    irw_s    = 1'b0;
    pcw_s    = 1'b0;
    rw_s     = 1'b0;
    ret_s    = 1'b0;
    IorD     = 1'b0;
    NPCOp    = 2'b00;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    ALUSrcB  = 1'b0;
    EXTOp    = 1'b0;
    ALUOp    = ALU_NOP;
    case (state_q)
      S_FETCH: begin
        req_s = 1'b1;
        if (mem_ack) begin
          irw_s   = 1'b1;
          pcw_s   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Illegal instructions retire here as a NOP with no architectural write.
        if (dec_class == C_ILL) begin
          ret_s   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_class)
          C_RALU: begin
            ALUOp   = dec_alu;
            state_d = S_WB;
          end
          C_IALU: begin
            ALUOp   = dec_alu;
            ALUSrcB = 1'b1;
            EXTOp   = dec_ext;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            ALUOp   = ALU_ADD;
            ALUSrcB = 1'b1;
            EXTOp   = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ, C_BNE: begin
            ALUOp   = ALU_SUB;
            NPCOp   = 2'b01;
            pcw_s   = (dec_class == C_BEQ) ? Zero : ~Zero;
            ret_s   = 1'b1;
            state_d = S_FETCH;
          end
          C_J, C_JAL: begin
            NPCOp   = 2'b10;
            pcw_s   = 1'b1;
            ret_s   = 1'b1;
            if (dec_class == C_JAL) begin
              rw_s   = 1'b1;
              GPRSel = 2'b10;
              WDSel  = 2'b10;
            end
            state_d = S_FETCH;
          end
          C_JR, C_JALR: begin
            NPCOp   = 2'b11;
            pcw_s   = 1'b1;
            ret_s   = 1'b1;
            if (dec_class == C_JALR) begin
              rw_s  = 1'b1;
              WDSel = 2'b10;
            end
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        req_s = 1'b1;
        IorD  = 1'b1;
        we_s  = (dec_class == C_SW);
        if (mem_ack) begin
          if (dec_class == C_SW) begin
            ret_s   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rw_s    = 1'b1;
        ret_s   = 1'b1;
        state_d = S_FETCH;
        case (dec_class)
          C_IALU:  GPRSel = 2'b01;
          C_LW:    begin GPRSel = 2'b01; WDSel = 2'b01; end
          default: GPRSel = 2'b00;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter: retries keep the request up; a full window without ack flags a timeout.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ack) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
    illegal_d = illegal_q | (state_q == S_DECODE && dec_class == C_ILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_req  = req_s & ~rst;
  assign mem_we   = we_s  & ~rst;
  assign IRWrite  = irw_s & ~rst;
  assign PCWrite  = pcw_s & ~rst;
  assign RegWrite = rw_s  & ~rst;
  assign retire   = ret_s & ~rst;
  assign state    = state_q;
  assign timeout  = timeout_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed bench for mccpu_ctrl: every cycle compares the full control word against a
// hand-built expected vector.
module tb_mccpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, mem_ack;
  logic       mem_req, mem_we, iord, irwrite, pcwrite, regwrite;
  logic [1:0] npcop, gprsel, wdsel;
  logic       alusrcb, extop, retire, timeout, illegal;
  logic [3:0] aluop;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_to  = 1'b0;
  logic exp_ill = 1'b0;

  always #5 clk = ~clk;

  mccpu_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .Op(op), .Funct(funct), .Zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(iord), .IRWrite(irwrite),
    .PCWrite(pcwrite), .NPCOp(npcop), .RegWrite(regwrite), .GPRSel(gprsel),
    .WDSel(wdsel), .ALUSrcB(alusrcb), .EXTOp(extop), .ALUOp(aluop),
    .state(state), .retire(retire), .timeout(timeout), .illegal(illegal)
  );

  wire [23:0] obs = {state, mem_req, mem_we, iord, irwrite, pcwrite, npcop, regwrite,
                     gprsel, wdsel, alusrcb, extop, aluop, retire, timeout, illegal};

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [23:0] ev(input logic [2:0] st, input logic req, we, io, irw, pcw,
                                     input logic [1:0] npc, input logic rw,
                                     input logic [1:0] gsel, wsel, input logic srcb, ext,
                                     input logic [3:0] alu, input logic ret);
    return {st, req, we, io, irw, pcw, npc, rw, gsel, wsel, srcb, ext, alu, ret, exp_to, exp_ill};
  endfunction

  function automatic logic [23:0] v_fetch_ack();
    return ev(3'd0, 1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0);
  endfunction
  function automatic logic [23:0] v_fetch_wait();
    return ev(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0);
  endfunction
  function automatic logic [23:0] v_decode();
    return ev(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0);
  endfunction

  // Inputs are set at posedge+1, outputs compared at posedge+2.
  task automatic step(input string tag, input logic [23:0] exp);
    #1;
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f; mem_ack = 1'b1;
    step("fetch", v_fetch_ack());
    step("decode", v_decode());
  endtask

  initial begin
    rst = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0; mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", obs, ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0));
    #1;
    rst = 1'b0;
    #1;

    // add, back-to-back with ack in the first cycle: 4-cycle loop
    for (int i = 0; i < 2; i++) begin
      fetch_decode(6'h00, 6'h20);
      step("add_exec", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd1, 0));
      step("add_wb",   ev(3'd4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 4'd0, 1));
    end

    // lw with ack two cycles late in MEM: 7 cycles
    fetch_decode(6'h23, 6'h00);
    step("lw_exec", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 4'd1, 0));
    mem_ack = 1'b0;
    step("lw_mem0", ev(3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0));
    step("lw_mem1", ev(3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0));
    mem_ack = 1'b1;
    step("lw_mem2", ev(3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0));
    step("lw_wb",   ev(3'd4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b01, 0, 0, 4'd0, 1));

    // sw: MEM with immediate ack retires
    fetch_decode(6'h2b, 6'h00);
    step("sw_exec", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 4'd1, 0));
    step("sw_mem",  ev(3'd3, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 1));

    // ori: zero-extended immediate, writes rt
    fetch_decode(6'h0d, 6'h00);
    step("ori_exec", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 4'd4, 0));
    step("ori_wb",   ev(3'd4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 4'd0, 1));

    // branches with both Zero values
    fetch_decode(6'h04, 6'h00); zero = 1'b1;
    step("beq_z1", ev(3'd2, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 4'd2, 1));
    fetch_decode(6'h04, 6'h00); zero = 1'b0;
    step("beq_z0", ev(3'd2, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 4'd2, 1));
    fetch_decode(6'h05, 6'h00); zero = 1'b1;
    step("bne_z1", ev(3'd2, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 4'd2, 1));
    fetch_decode(6'h05, 6'h00); zero = 1'b0;
    step("bne_z0", ev(3'd2, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 4'd2, 1));

    // jumps
    fetch_decode(6'h02, 6'h00);
    step("j_exec",    ev(3'd2, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 4'd0, 1));
    fetch_decode(6'h03, 6'h00);
    step("jal_exec",  ev(3'd2, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b10, 0, 0, 4'd0, 1));
    fetch_decode(6'h00, 6'h08);
    step("jr_exec",   ev(3'd2, 0, 0, 0, 0, 1, 2'b11, 0, 2'b00, 2'b00, 0, 0, 4'd0, 1));
    fetch_decode(6'h00, 6'h09);
    step("jalr_exec", ev(3'd2, 0, 0, 0, 0, 1, 2'b11, 1, 2'b00, 2'b10, 0, 0, 4'd0, 1));

    // FETCH timeout: flag appears after 16 unacked cycles, request held, then ack proceeds
    op = 6'h00; funct = 6'h22; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) step("to_wait", v_fetch_wait());
    exp_to = 1'b1;
    step("to_set", v_fetch_wait());
    step("to_hold", v_fetch_wait());
    mem_ack = 1'b1;
    step("to_ack", v_fetch_ack());
    step("to_decode", v_decode());
    step("sub_exec", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd2, 0));
    step("sub_wb",   ev(3'd4, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 4'd0, 1));

    // illegal opcode: retire from DECODE, no writes, flag sticks
    op = 6'h3f; funct = 6'h00;
    step("ill_fetch", v_fetch_ack());
    step("ill_decode", ev(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 1));
    exp_ill = 1'b1;

    // rst while sw waits in MEM
    fetch_decode(6'h2b, 6'h00);
    step("sw2_exec", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 4'd1, 0));
    mem_ack = 1'b0;
    step("sw2_mem", ev(3'd3, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0));
    rst = 1'b1;
    step("sw2_rst", ev(3'd3, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 4'd0, 0));
    rst = 1'b0; exp_to = 1'b0; exp_ill = 1'b0; mem_ack = 1'b1;
    step("post_rst", v_fetch_ack());
    step("post_rst_dec", v_decode());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
